// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if
//   Bundles the load/store-queue side and the memory side of the data cache
//   controller into one interface.
//
//   LSQ read   : rd_en, rd_gnt, rd_tag, rd_idx, rd_offset, rd_size
//   LSQ write  : wr_en, wr_tag, wr_idx, wr_offset, wr_data, wr_size, wr_ready
//   LSQ return : dc_feedback/dc_data (hit), mem_feedback/mem_data (filled miss)
//   Memory cmd : mem_req_valid, mem_req_store, mem_req_addr, mem_req_data,
//                mem_req_size, mem_req_ready
//   Memory resp: mem_resp_valid, mem_resp_data
//
//   Modports: master = LSQ + memory model, slave = the cache controller.
// ---------------------------------------------------------------------------
interface dcache_ctrl_if #(
    parameter int LSQSZ = 16
);
    logic             rd_en;
    logic [LSQSZ-1:0] rd_gnt;
    logic [7:0]       rd_tag;
    logic [4:0]       rd_idx;
    logic [2:0]       rd_offset;
    logic [1:0]       rd_size;

    logic             wr_en;
    logic [7:0]       wr_tag;
    logic [4:0]       wr_idx;
    logic [2:0]       wr_offset;
    logic [31:0]      wr_data;
    logic [1:0]       wr_size;
    logic             wr_ready;

    logic [LSQSZ-1:0] dc_feedback;
    logic [31:0]      dc_data;
    logic [LSQSZ-1:0] mem_feedback;
    logic [31:0]      mem_data;

    logic             mem_req_valid;
    logic             mem_req_store;
    logic [15:0]      mem_req_addr;
    logic [31:0]      mem_req_data;
    logic [1:0]       mem_req_size;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [63:0]      mem_resp_data;

    modport master (
        output rd_en, rd_gnt, rd_tag, rd_idx, rd_offset, rd_size,
        output wr_en, wr_tag, wr_idx, wr_offset, wr_data, wr_size,
        input  wr_ready, dc_feedback, dc_data, mem_feedback, mem_data,
        input  mem_req_valid, mem_req_store, mem_req_addr, mem_req_data, mem_req_size,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  rd_en, rd_gnt, rd_tag, rd_idx, rd_offset, rd_size,
        input  wr_en, wr_tag, wr_idx, wr_offset, wr_data, wr_size,
        output wr_ready, dc_feedback, dc_data, mem_feedback, mem_data,
        output mem_req_valid, mem_req_store, mem_req_addr, mem_req_data, mem_req_size,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped data cache responder, 32 sets x 8-byte lines, 8-bit tags.
//   Read hits answer combinationally; a read miss starts the single
//   outstanding line fill (IDLE -> REQ -> WAIT -> FILL). Stores are
//   write-through / no-allocate and go through a WB_DEPTH-entry FIFO that
//   always drains ahead of a pending line fetch.
//
//   Ports:
//     clock     rising-edge clock
//     reset     asynchronous, active-low
//     bus       dcache_ctrl_if.slave (LSQ and memory handshakes)
//   Optional (macro DC_STATS_EN):
//     hit_cnt   saturating count of read hits
//     miss_cnt  saturating count of accepted read misses
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LSQSZ    = 16,
    parameter int WB_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    dcache_ctrl_if.slave bus
`ifdef DC_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int WB_AW = $clog2(WB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    // Select the addressed lane and zero-extend to the access size.
    function automatic logic [31:0] extract(input logic [63:0] ln,
                                            input logic [2:0]  off,
                                            input logic [1:0]  size);
        logic [63:0] sh;
        sh = ln >> {off, 3'b000};
        case (size)
            2'd0:    extract = {24'd0, sh[7:0]};
            2'd1:    extract = {16'd0, sh[15:0]};
            default: extract = sh[31:0];
        endcase
    endfunction

    // ---------------- storage ----------------
    logic [63:0] data_q [32];
    logic [7:0]  tag_q  [32];
    logic [31:0] valid_q;

    // ---------------- miss FSM state ----------------
    state_t           state_q, state_d;
    logic [LSQSZ-1:0] gnt_q;
    logic [7:0]       miss_tag_q;
    logic [4:0]       miss_idx_q;
    logic [2:0]       miss_off_q;
    logic [1:0]       miss_size_q;
    logic [63:0]      fill_line_q;
    logic             drop_q;       // a store hit the in-flight line: do not install the fill

    // ---------------- write buffer ----------------
    logic [15:0]      wb_addr_q [WB_DEPTH];
    logic [31:0]      wb_data_q [WB_DEPTH];
    logic [1:0]       wb_size_q [WB_DEPTH];
    logic [WB_AW-1:0] wb_wptr_q, wb_rptr_q;
    logic [WB_AW:0]   wb_cnt_q;
    logic             wb_empty, wb_push, wb_pop, wr_ready_int;

    // ---------------- read path ----------------
    logic rd_hit;
    assign rd_hit = bus.rd_en && valid_q[bus.rd_idx] && (tag_q[bus.rd_idx] == bus.rd_tag);

    assign bus.dc_feedback = rd_hit ? bus.rd_gnt : '0;
    assign bus.dc_data     = rd_hit ? extract(data_q[bus.rd_idx], bus.rd_offset, bus.rd_size) : 32'd0;

    // ---------------- store path ----------------
    logic        wr_accept, wr_hit, store_to_miss;
    logic [7:0]  wr_bmask_base, wr_bmask;
    logic [63:0] wr_shift, wr_old_line, wr_merged;

    assign wr_ready_int = (wb_cnt_q != (WB_AW + 1)'(WB_DEPTH));
    assign bus.wr_ready = wr_ready_int;
    assign wr_accept    = bus.wr_en && wr_ready_int;
    assign wr_hit       = valid_q[bus.wr_idx] && (tag_q[bus.wr_idx] == bus.wr_tag);
    assign store_to_miss = wr_accept && (bus.wr_idx == miss_idx_q) && (bus.wr_tag == miss_tag_q);

    always_comb begin
        case (bus.wr_size)
            2'd0:    wr_bmask_base = 8'h01;
            2'd1:    wr_bmask_base = 8'h03;
            default: wr_bmask_base = 8'h0F;
        endcase
    end

    assign wr_bmask    = wr_bmask_base << bus.wr_offset;
    assign wr_shift    = {32'd0, bus.wr_data} << {bus.wr_offset, 3'b000};
    assign wr_old_line = data_q[bus.wr_idx];

    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
        assign wr_merged[gi*8 +: 8] = wr_bmask[gi] ? wr_shift[gi*8 +: 8] : wr_old_line[gi*8 +: 8];
    end

    // ---------------- FSM next state ----------------
    logic miss_accept, fetch_fire, fill_we;

    assign wb_empty = (wb_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        miss_accept = 1'b0;
        fetch_fire  = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_en && !rd_hit) begin
                    miss_accept = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // Pending stores go to memory first so the fetched line is current.
                if (wb_empty && bus.mem_req_ready) begin
                    fetch_fire = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    fill_we = !(drop_q || store_to_miss);
                    state_d = S_FILL;
                end
            end
            S_FILL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- memory command / LSQ return outputs ----------------
    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_req_store = 1'b0;
        bus.mem_req_addr  = 16'd0;
        bus.mem_req_data  = 32'd0;
        bus.mem_req_size  = 2'd0;
        bus.mem_feedback  = '0;
        bus.mem_data      = 32'd0;
        if (!wb_empty) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_store = 1'b1;
            bus.mem_req_addr  = wb_addr_q[wb_rptr_q];
            bus.mem_req_data  = wb_data_q[wb_rptr_q];
            bus.mem_req_size  = wb_size_q[wb_rptr_q];
        end else if (state_q == S_REQ) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = {miss_tag_q, miss_idx_q, 3'b000};
        end
        if (state_q == S_FILL) begin
            bus.mem_feedback = gnt_q;
            bus.mem_data     = extract(fill_line_q, miss_off_q, miss_size_q);
        end
    end

    assign wb_push = wr_accept;
    assign wb_pop  = !wb_empty && bus.mem_req_ready;

    // ---------------- control registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            gnt_q       <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            miss_off_q  <= '0;
            miss_size_q <= '0;
            fill_line_q <= '0;
            drop_q      <= 1'b0;
            wb_wptr_q   <= '0;
            wb_rptr_q   <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (miss_accept) begin
                gnt_q       <= bus.rd_gnt;
                miss_tag_q  <= bus.rd_tag;
                miss_idx_q  <= bus.rd_idx;
                miss_off_q  <= bus.rd_offset;
                miss_size_q <= bus.rd_size;
                drop_q      <= 1'b0;
            end else if (store_to_miss && (fetch_fire || state_q == S_WAIT)) begin
                // Fetch already ordered ahead of this store: the returned line is stale.
                drop_q <= 1'b1;
            end
            if (state_q == S_WAIT && bus.mem_resp_valid) begin
                fill_line_q <= bus.mem_resp_data;
            end
            if (fill_we) begin
                valid_q[miss_idx_q] <= 1'b1;
            end
            if (wb_push) wb_wptr_q <= wb_wptr_q + 1'b1;
            if (wb_pop)  wb_rptr_q <= wb_rptr_q + 1'b1;
            case ({wb_push, wb_pop})
                2'b10:   wb_cnt_q <= wb_cnt_q + 1'b1;
                2'b01:   wb_cnt_q <= wb_cnt_q - 1'b1;
                default: wb_cnt_q <= wb_cnt_q;
            endcase
        end
    end

    // ---------------- arrays (no reset; guarded by valid_q / pointers) ----------------
    always_ff @(posedge clock) begin
        if (wr_accept && wr_hit) begin
            data_q[bus.wr_idx] <= wr_merged;
        end
        // Fill is last so it overrides a same-edge store merge into the set being replaced.
        if (fill_we) begin
            data_q[miss_idx_q] <= bus.mem_resp_data;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
        if (wb_push) begin
            wb_addr_q[wb_wptr_q] <= {bus.wr_tag, bus.wr_idx, bus.wr_offset};
            wb_data_q[wb_wptr_q] <= bus.wr_data;
            wb_size_q[wb_wptr_q] <= bus.wr_size;
        end
    end

`ifdef DC_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit && hit_cnt_q != '1)       hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss_accept && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dcache_ctrl_if #(.LSQSZ(16)) bus ();

`ifdef DC_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl #(.LSQSZ(16), .WB_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DC_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] idx, input logic [7:0] tag, input logic [2:0] off,
                      input logic [1:0] size, input logic [15:0] gnt);
        bus.rd_en     = 1'b1;
        bus.rd_idx    = idx;
        bus.rd_tag    = tag;
        bus.rd_offset = off;
        bus.rd_size   = size;
        bus.rd_gnt    = gnt;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [7:0] tag, input logic [2:0] off,
                      input logic [1:0] size, input logic [31:0] data);
        bus.wr_en     = 1'b1;
        bus.wr_idx    = idx;
        bus.wr_tag    = tag;
        bus.wr_offset = off;
        bus.wr_size   = size;
        bus.wr_data   = data;
    endtask

    initial begin
        reset              = 1'b0;
        bus.rd_en          = 1'b0;
        bus.rd_gnt         = '0;
        bus.rd_tag         = '0;
        bus.rd_idx         = '0;
        bus.rd_offset      = '0;
        bus.rd_size        = '0;
        bus.wr_en          = 1'b0;
        bus.wr_tag         = '0;
        bus.wr_idx         = '0;
        bus.wr_offset      = '0;
        bus.wr_data        = '0;
        bus.wr_size        = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        // Reset state
        #12;
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_dc_feedback", bus.dc_feedback, 0);
        chk("rst_mem_feedback", bus.mem_feedback, 0);
        chk("rst_mem_data", bus.mem_data, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        $display("reset released");

        // 1: cold read miss idx3 tag 0x12
        rd(3, 8'h12, 0, 2, 16'h0004);
        settle();
        chk("t1_miss_dcfb", bus.dc_feedback, 0);
        tick();
        bus.rd_en = 1'b0;
        settle();
        chk("t1_fetch_valid", bus.mem_req_valid, 1);
        chk("t1_fetch_store", bus.mem_req_store, 0);
        chk("t1_fetch_addr", bus.mem_req_addr, 16'h1218);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        settle();
        chk("t1_wait_no_req", bus.mem_req_valid, 0);
        $display("t1 fetch issued addr=1218");

        // 5: second miss while WAIT is dropped
        rd(5, 8'h34, 0, 2, 16'h0008);
        settle();
        chk("t5_miss_dcfb", bus.dc_feedback, 0);
        tick();
        bus.rd_en = 1'b0;
        settle();
        chk("t5_no_second_fetch", bus.mem_req_valid, 0);
        $display("t5 second miss dropped");

        // 1 cont.: response, FILL pulse; hit to the filled line in FILL sees new data
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h1122334455667788;
        tick();
        bus.mem_resp_valid = 1'b0;
        rd(3, 8'h12, 4, 1, 16'h0100);
        settle();
        chk("t1_mem_feedback", bus.mem_feedback, 16'h0004);
        chk("t1_mem_data", bus.mem_data, 32'h55667788);
        chk("fill_cycle_hit_fb", bus.dc_feedback, 16'h0100);
        chk("fill_cycle_hit_data", bus.dc_data, 32'h00003344);
        $display("t1 fill returned 55667788");

        // 2: repeat read, now IDLE
        tick();
        settle();
        chk("t2_hit_fb", bus.dc_feedback, 16'h0100);
        chk("t2_hit_data", bus.dc_data, 32'h00003344);
        chk("t2_fb_pulse_end", bus.mem_feedback, 0);
        tick();
        bus.rd_en = 1'b0;
        settle();
        chk("t2_no_fetch", bus.mem_req_valid, 0);
        chk("t2_idle_dc_data", bus.dc_data, 0);
        $display("t2 hit data 3344");

        // 3: store byte to hit line, then read back
        wr(3, 8'h12, 1, 0, 32'h000000AB);
        settle();
        chk("t3_wr_ready", bus.wr_ready, 1);
        tick();
        bus.wr_en = 1'b0;
        rd(3, 8'h12, 0, 2, 16'h0001);
        settle();
        chk("t3_merged_data", bus.dc_data, 32'h5566AB88);
        chk("t3_hit_fb", bus.dc_feedback, 16'h0001);
        chk("t3_store_valid", bus.mem_req_valid, 1);
        chk("t3_store_flag", bus.mem_req_store, 1);
        chk("t3_store_addr", bus.mem_req_addr, 16'h1219);
        chk("t3_store_data", bus.mem_req_data, 32'h000000AB);
        chk("t3_store_size", bus.mem_req_size, 0);
        bus.rd_en = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        settle();
        chk("t3_drained", bus.mem_req_valid, 0);
        $display("t3 store merged, drained addr=1219");

        // 4: five stores with memory stalled
        for (int i = 0; i < 5; i++) begin
            wr(5'(i), 8'(32'h40 + i), 0, 2, 32'hC0DE0000 + i);
            settle();
            chk("t4_wr_ready", bus.wr_ready, (i < 4) ? 1 : 0);
            tick();
        end
        bus.wr_en = 1'b0;
        settle();
        chk("t4_full", bus.wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", bus.mem_req_valid, 1);
            chk("t4_drain_store", bus.mem_req_store, 1);
            chk("t4_drain_addr", bus.mem_req_addr, 16'((32'h40 + i) * 256 + i * 8));
            chk("t4_drain_data", bus.mem_req_data, 32'hC0DE0000 + i);
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            settle();
            $display("t4 drained entry %0d", i);
        end
        chk("t4_empty", bus.mem_req_valid, 0);
        chk("t4_ready_again", bus.wr_ready, 1);

        // Store to in-flight miss line during WAIT: fill returned but not installed
        rd(7, 8'h20, 0, 2, 16'h0010);
        settle();
        chk("drop_miss_dcfb", bus.dc_feedback, 0);
        tick();
        bus.rd_en = 1'b0;
        settle();
        chk("drop_fetch_addr", bus.mem_req_addr, 16'h2038);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        wr(7, 8'h20, 0, 2, 32'hDEADBEEF);
        tick();
        bus.wr_en = 1'b0;
        settle();
        chk("drop_drain_in_wait", bus.mem_req_store, 1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hCAFEF00D12345678;
        tick();
        bus.mem_resp_valid = 1'b0;
        settle();
        chk("drop_mem_feedback", bus.mem_feedback, 16'h0010);
        chk("drop_mem_data", bus.mem_data, 32'h12345678);
        tick();
        rd(7, 8'h20, 0, 2, 16'h0010);
        settle();
        chk("drop_line_invalid", bus.dc_feedback, 0);
        tick();
        bus.rd_en = 1'b0;
        settle();
        chk("drop_drain_first", bus.mem_req_store, 1);
        chk("drop_drain_data", bus.mem_req_data, 32'hDEADBEEF);
        bus.mem_req_ready = 1'b1;
        tick();
        chk("refetch_store", bus.mem_req_store, 0);
        chk("refetch_valid", bus.mem_req_valid, 1);
        chk("refetch_addr", bus.mem_req_addr, 16'h2038);
        tick();
        bus.mem_req_ready = 1'b0;
        settle();
        chk("refetch_wait", bus.mem_req_valid, 0);
        $display("store-in-WAIT fill dropped, refetch in WAIT");

        // 6: reset during WAIT, late response ignored
        reset = 1'b0;
        settle();
        chk("t6_rst_req_valid", bus.mem_req_valid, 0);
        chk("t6_rst_wr_ready", bus.wr_ready, 1);
        #3;
        reset = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hFFFFFFFFFFFFFFFF;
        tick();
        bus.mem_resp_valid = 1'b0;
        settle();
        chk("t6_no_feedback_a", bus.mem_feedback, 0);
        tick();
        chk("t6_no_feedback_b", bus.mem_feedback, 0);
        rd(7, 8'h20, 0, 2, 16'h0010);
        settle();
        chk("t6_line7_invalid", bus.dc_feedback, 0);
        rd(3, 8'h12, 0, 2, 16'h0001);
        settle();
        chk("t6_line3_invalid", bus.dc_feedback, 0);
        bus.rd_en = 1'b0;
        $display("t6 reset mid-miss handled");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
